// File: rtl/score_keeper_pkg.sv
// ---------------------------------------------------------------------------
// score_keeper_pkg
//   Shared definitions for the score keeper: game state and winner
//   encodings, score width, and small helpers for the saturating score
//   and the end-of-game winner decision.
// ---------------------------------------------------------------------------
package score_keeper_pkg;

    localparam int SCORE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ARM  = 2'b01,
        ST_PLAY = 2'b10,
        ST_OVER = 2'b11
    } game_state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_TIE  = 2'b11
    } winner_e;

    // Increment that sticks at the ceiling instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] value,
                                                   input logic [SCORE_W-1:0] ceiling);
        return (value >= ceiling) ? ceiling : value + SCORE_W'(1);
    endfunction

    // A one-player game always credits player 1; otherwise the higher score wins.
    function automatic winner_e pick_winner(input logic               two_player,
                                            input logic [SCORE_W-1:0] p1_score,
                                            input logic [SCORE_W-1:0] p2_score);
        if (!two_player)
            return WIN_P1;
        if (p1_score > p2_score)
            return WIN_P1;
        if (p2_score > p1_score)
            return WIN_P2;
        return WIN_TIE;
    endfunction

endpackage

// File: rtl/score_keeper_counter.sv
// ---------------------------------------------------------------------------
// score_counter
//   One player's score: accepts hit pulses while enabled and not locked
//   out, counts them into a saturating score, and after each accepted hit
//   ignores further hits for LOCK_FRAMES frame ticks.
//
//   clk     in  pixel clock
//   rst     in  synchronous, active-low reset
//   clear   in  clears score and lockout (game arming)
//   enable  in  hits may be counted this clk
//   tick    in  one-clk frame tick
//   hit     in  one-clk hit pulse
//   score   out saturating binary score
// ---------------------------------------------------------------------------
module score_counter
    import score_keeper_pkg::*;
#(
    parameter int MAX_SCORE   = 99,
    parameter int LOCK_FRAMES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               enable,
    input  logic               tick,
    input  logic               hit,
    output logic [SCORE_W-1:0] score
);

    localparam int                 LOCK_W    = (LOCK_FRAMES > 0) ? $clog2(LOCK_FRAMES + 1) : 1;
    localparam logic [LOCK_W-1:0]  LOCK_LOAD = LOCK_W'(LOCK_FRAMES);
    localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(MAX_SCORE);

    logic [LOCK_W-1:0] lock;
    logic              accept;

    assign accept = enable & hit & (lock == '0);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            score <= '0;
            lock  <= '0;
        end else if (clear) begin
            score <= '0;
            lock  <= '0;
        end else if (accept) begin
            // A load on the same clk as a tick takes priority over the decrement.
            score <= sat_inc(score, SCORE_MAX);
            lock  <= LOCK_LOAD;
        end else if (tick && lock != '0) begin
            lock  <= lock - LOCK_W'(1);
        end
    end

endmodule

// File: rtl/score_keeper.sv
// ---------------------------------------------------------------------------
// score_keeper
//   Game-control stage ahead of the HUD overlay: frame-tick extraction from
//   vsync, start-button debounce, IDLE/ARM/PLAY/OVER game FSM, per-player
//   score counters and the winner latch.
//
//   clk           in   pixel clock
//   rst           in   synchronous, active-low reset
//   vsync_in      in   VGA vsync; rising edge marks a frame
//   start_btn     in   raw start button level
//   NoOfPlayers   in   0 = one player, 1 = two players (sampled in ARM)
//   p1_hit        in   player 1 hit pulse
//   p2_hit        in   player 2 hit pulse
//   TimeOut       in   game-over flag from the overlay
//   Player1Score  out  player 1 score
//   Player2Score  out  player 2 score
//   game_state    out  00 IDLE, 01 ARM, 10 PLAY, 11 OVER
//   game_active   out  high only in PLAY
//   winner        out  00 none, 01 P1, 10 P2, 11 tie (valid in OVER)
//   timer_rst_n   out  low in IDLE/ARM, high in PLAY/OVER
// ---------------------------------------------------------------------------
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int MAX_SCORE    = 99,
    parameter int LOCK_FRAMES  = 2,
    parameter int START_FRAMES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vsync_in,
    input  logic               start_btn,
    input  logic               NoOfPlayers,
    input  logic               p1_hit,
    input  logic               p2_hit,
    input  logic               TimeOut,
    output logic [SCORE_W-1:0] Player1Score,
    output logic [SCORE_W-1:0] Player2Score,
    output logic [1:0]         game_state,
    output logic               game_active,
    output logic [1:0]         winner,
    output logic               timer_rst_n
);

    localparam int              ST_W   = (START_FRAMES > 0) ? $clog2(START_FRAMES + 1) : 1;
    localparam logic [ST_W-1:0] ST_MAX = ST_W'(START_FRAMES);

    logic              vsync_q;
    logic              vsync_q2;
    logic              tick;
    logic [ST_W-1:0]   st_cnt;
    logic              start_ok;
    game_state_e       state;
    winner_e           winner_r;
    logic              mode_r;
    logic              play_open;

    // ---------------- frame tick ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            vsync_q  <= 1'b0;
            vsync_q2 <= 1'b0;
        end else begin
            vsync_q  <= vsync_in;
            vsync_q2 <= vsync_q;
        end
    end

    assign tick = vsync_q & ~vsync_q2;

    // ---------------- start debounce ----------------
    // Counts consecutive frames with the button held; any low sample restarts it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            st_cnt <= '0;
        end else if (tick) begin
            if (!start_btn)
                st_cnt <= '0;
            else if (st_cnt != ST_MAX)
                st_cnt <= st_cnt + ST_W'(1);
        end
    end

    assign start_ok = (st_cnt == ST_MAX);

    // ---------------- game FSM ----------------
    // game_active and timer_rst_n are registered alongside the state and only
    // change on the transitions that enter or leave PLAY / OVER.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            mode_r      <= 1'b0;
            winner_r    <= WIN_NONE;
            game_active <= 1'b0;
            timer_rst_n <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok)
                        state <= ST_ARM;
                end
                ST_ARM: begin
                    state       <= ST_PLAY;
                    mode_r      <= NoOfPlayers;
                    winner_r    <= WIN_NONE;
                    game_active <= 1'b1;
                    timer_rst_n <= 1'b1;
                end
                ST_PLAY: begin
                    // Hits are blocked while TimeOut is high, so the scores seen
                    // here are final.
                    if (TimeOut) begin
                        state       <= ST_OVER;
                        winner_r    <= pick_winner(mode_r, Player1Score, Player2Score);
                        game_active <= 1'b0;
                    end
                end
                ST_OVER: begin
                    // Wait for the button to be seen released on a frame so a
                    // held press cannot immediately rearm.
                    if (tick && !start_btn) begin
                        state       <= ST_IDLE;
                        timer_rst_n <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    game_active <= 1'b0;
                    timer_rst_n <= 1'b0;
                end
            endcase
        end
    end

    assign game_state = state;
    assign winner     = winner_r;

    // ---------------- score counters ----------------
    assign play_open = (state == ST_PLAY) & ~TimeOut;

    score_counter #(
        .MAX_SCORE  (MAX_SCORE),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) u_p1 (
        .clk   (clk),
        .rst   (rst),
        .clear (state == ST_ARM),
        .enable(play_open),
        .tick  (tick),
        .hit   (p1_hit),
        .score (Player1Score)
    );

    score_counter #(
        .MAX_SCORE  (MAX_SCORE),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) u_p2 (
        .clk   (clk),
        .rst   (rst),
        .clear (state == ST_ARM),
        .enable(play_open & mode_r),
        .tick  (tick),
        .hit   (p2_hit),
        .score (Player2Score)
    );

endmodule

// File: tb/tb_score_keeper.sv
// ---------------------------------------------------------------------------
// tb_score_keeper
//   Directed game scenarios followed by random play. A frame-level model of
//   the game rules is advanced on every rising clock edge and every output is
//   compared against it on the falling edge; directed scenarios add literal
//   expectations.
// ---------------------------------------------------------------------------
module tb_score_keeper;

    localparam int VS_PERIOD    = 12;
    localparam int VS_HIGH      = 3;
    localparam int MAX_SCORE    = 99;
    localparam int LOCK_FRAMES  = 2;
    localparam int START_FRAMES = 3;

    logic       clk         = 1'b0;
    logic       rst         = 1'b0;
    logic       vsync_in    = 1'b0;
    logic       start_btn   = 1'b0;
    logic       NoOfPlayers = 1'b0;
    logic       p1_hit      = 1'b0;
    logic       p2_hit      = 1'b0;
    logic       TimeOut     = 1'b0;
    logic [7:0] Player1Score;
    logic [7:0] Player2Score;
    logic [1:0] game_state;
    logic       game_active;
    logic [1:0] winner;
    logic       timer_rst_n;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    score_keeper dut (
        .clk         (clk),
        .rst         (rst),
        .vsync_in    (vsync_in),
        .start_btn   (start_btn),
        .NoOfPlayers (NoOfPlayers),
        .p1_hit      (p1_hit),
        .p2_hit      (p2_hit),
        .TimeOut     (TimeOut),
        .Player1Score(Player1Score),
        .Player2Score(Player2Score),
        .game_state  (game_state),
        .game_active (game_active),
        .winner      (winner),
        .timer_rst_n (timer_rst_n)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- free-running vsync ----------------
    initial begin
        forever begin
            for (int i = 0; i < VS_PERIOD; i++) begin
                @(negedge clk);
                vsync_in = (i < VS_HIGH);
            end
        end
    end

    // ---------------- reference model ----------------
    // States: 0 idle, 1 arm, 2 play, 3 over. Winner: 0 none, 1 P1, 2 P2, 3 tie.
    int m_vs_last, m_vs_prev, m_press, m_state, m_mode, m_win;
    int m_s1, m_s2, m_l1, m_l2;

    initial begin
        m_vs_last = 0; m_vs_prev = 0; m_press = 0; m_state = 0; m_mode = 0; m_win = 0;
        m_s1 = 0; m_s2 = 0; m_l1 = 0; m_l2 = 0;
    end

    always @(posedge clk) begin : model
        int frame, old_state, open, take1, take2;
        if (!rst) begin
            m_vs_last = 0; m_vs_prev = 0; m_press = 0; m_state = 0; m_mode = 0; m_win = 0;
            m_s1 = 0; m_s2 = 0; m_l1 = 0; m_l2 = 0;
        end else begin
            frame     = (m_vs_last == 1 && m_vs_prev == 0);
            old_state = m_state;
            open      = (old_state == 2) && !TimeOut;
            take1     = open && p1_hit && (m_l1 == 0);
            take2     = open && (m_mode == 1) && p2_hit && (m_l2 == 0);

            case (old_state)
                0: if (m_press == START_FRAMES) m_state = 1;
                1: begin m_state = 2; m_mode = NoOfPlayers; m_win = 0; end
                2: if (TimeOut) begin
                       m_state = 3;
                       if (m_mode == 0)      m_win = 1;
                       else if (m_s1 > m_s2) m_win = 1;
                       else if (m_s2 > m_s1) m_win = 2;
                       else                  m_win = 3;
                   end
                3: if (frame && !start_btn) m_state = 0;
                default: m_state = 0;
            endcase

            if (old_state == 1) begin
                m_s1 = 0; m_s2 = 0; m_l1 = 0; m_l2 = 0;
            end else begin
                if (take1) begin
                    m_s1 = (m_s1 + 1 > MAX_SCORE) ? MAX_SCORE : m_s1 + 1;
                    m_l1 = LOCK_FRAMES;
                end else if (frame && m_l1 > 0) m_l1--;
                if (take2) begin
                    m_s2 = (m_s2 + 1 > MAX_SCORE) ? MAX_SCORE : m_s2 + 1;
                    m_l2 = LOCK_FRAMES;
                end else if (frame && m_l2 > 0) m_l2--;
            end

            if (frame) m_press = start_btn ? ((m_press < START_FRAMES) ? m_press + 1 : START_FRAMES) : 0;
            m_vs_prev = m_vs_last;
            m_vs_last = vsync_in;
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("state",       game_state,   m_state);
            check("p1_score",    Player1Score, m_s1);
            check("p2_score",    Player2Score, m_s2);
            check("winner",      winner,       m_win);
            check("game_active", game_active,  m_state == 2);
            check("timer_rst_n", timer_rst_n,  m_state >= 2);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, output int waited);
        waited = 0;
        while (game_state !== s && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check("wait_state", game_state, s);
    endtask

    task automatic start_game(input logic two_player);
        int waited;
        NoOfPlayers = two_player;
        start_btn   = 1'b1;
        wait_state(2'b01, 6 * VS_PERIOD, waited);
        check("start_needs_3_frames", waited >= 2 * VS_PERIOD, 1);
        check("arm_timer_rst_n", timer_rst_n, 0);
        cyc(1);
        check("arm_one_clk",      game_state,   2'b10);
        check("play_timer_rst_n", timer_rst_n,  1);
        check("play_active",      game_active,  1);
        check("arm_clears_p1",    Player1Score, 0);
        check("arm_clears_p2",    Player2Score, 0);
        start_btn = 1'b0;
    endtask

    task automatic hit(input logic h1, input logic h2);
        p1_hit = h1;
        p2_hit = h2;
        cyc(1);
        p1_hit = 1'b0;
        p2_hit = 1'b0;
        cyc(3 * VS_PERIOD);
    endtask

    task automatic end_game(input logic [1:0] exp_winner, input logic p2_with_timeout);
        TimeOut = 1'b1;
        p2_hit  = p2_with_timeout;
        cyc(1);
        TimeOut = 1'b0;
        p2_hit  = 1'b0;
        check("over_state",  game_state,  2'b11);
        check("over_winner", winner,      exp_winner);
        check("over_active", game_active, 0);
    endtask

    task automatic go_idle();
        int waited;
        start_btn = 1'b0;
        wait_state(2'b00, 3 * VS_PERIOD, waited);
    endtask

    // ---------------- directed + random scenarios ----------------
    initial begin
        rst = 1'b0;
        cyc(3);
        cmp_en = 1'b1;
        check("reset_state",  game_state,   0);
        check("reset_p1",     Player1Score, 0);
        check("reset_timer",  timer_rst_n,  0);
        rst = 1'b1;

        // Debounce is not satisfied by a short press.
        start_btn = 1'b1;
        cyc(VS_PERIOD);
        start_btn = 1'b0;
        cyc(2 * VS_PERIOD);
        check("short_press_idle", game_state, 0);

        // Two-player game, player 1 hammering the hit line for 5 frames.
        start_game(1'b1);
        p1_hit = 1'b1;
        cyc(5 * VS_PERIOD);
        p1_hit = 1'b0;
        cyc(3 * VS_PERIOD);
        check("lock_p2_unchanged", Player2Score, 0);
        end_game(2'b01, 1'b0);
        go_idle();

        // Simultaneous hits, then 7:4 with a hit lost to TimeOut.
        start_game(1'b1);
        hit(1'b1, 1'b1);
        check("sim_p1", Player1Score, 1);
        check("sim_p2", Player2Score, 1);
        repeat (6) hit(1'b1, 1'b0);
        repeat (3) hit(1'b0, 1'b1);
        check("pre_over_p1", Player1Score, 7);
        check("pre_over_p2", Player2Score, 4);
        end_game(2'b01, 1'b1);
        check("timeout_blocks_p2", Player2Score, 4);

        // Held button keeps OVER; release returns to IDLE; press rearms.
        start_btn = 1'b1;
        cyc(3 * VS_PERIOD);
        check("held_stays_over", game_state, 2'b11);
        check("over_holds_p1",   Player1Score, 7);
        go_idle();
        check("idle_holds_p1",   Player1Score, 7);
        start_game(1'b1);

        // Tie.
        repeat (2) hit(1'b1, 1'b1);
        end_game(2'b11, 1'b0);
        go_idle();

        // One-player mode ignores player 2.
        start_game(1'b0);
        repeat (2) hit(1'b0, 1'b1);
        check("1p_p2_ignored", Player2Score, 0);
        end_game(2'b01, 1'b0);
        go_idle();

        // Player 2 wins.
        start_game(1'b1);
        hit(1'b0, 1'b1);
        end_game(2'b10, 1'b0);
        go_idle();

        // Saturation at 99.
        start_game(1'b1);
        repeat (100) hit(1'b1, 1'b0);
        check("saturate_p1", Player1Score, 8'h63);
        end_game(2'b01, 1'b0);
        go_idle();

        // Reset in the middle of play.
        start_game(1'b1);
        repeat (5) hit(1'b1, 1'b0);
        check("mid_play_p1", Player1Score, 5);
        rst = 1'b0;
        cyc(3);
        rst = 1'b1;
        check("midreset_state",  game_state,   0);
        check("midreset_p1",     Player1Score, 0);
        check("midreset_timer",  timer_rst_n,  0);
        check("midreset_winner", winner,       0);

        // Random play against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) start_btn = ~start_btn;
            NoOfPlayers = 1'($urandom_range(0, 1));
            p1_hit      = ($urandom_range(0, 5) == 0);
            p2_hit      = ($urandom_range(0, 5) == 0);
            TimeOut     = ($urandom_range(0, 249) == 0);
            cyc(1);
        end
        start_btn = 1'b0; p1_hit = 1'b0; p2_hit = 1'b0; TimeOut = 1'b0;
        cyc(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
